// File: rtl/microstep_decode_if.sv
// microstep_decode_if: fetch handshake, per-step ALU control and EIP-advance bus of microstep_decode.
interface microstep_decode_if #(
    parameter int OPE_W = 32,
    parameter int SEL_W = 4,
    parameter int MAX_STEPS = 3,
    parameter int STEP_W = $clog2(MAX_STEPS)
);
    logic [OPE_W-1:0] ope;
    logic ope_valid;
    logic ope_ready;
    logic step_ack;
    logic step_valid;
    logic [SEL_W-1:0] reg_load;
    logic [SEL_W-1:0] select;
    logic [STEP_W-1:0] step_idx;
    logic last_step;
    logic adv_valid;
    logic [3:0] num_of_ope;
    logic illegal;
    logic fault;
    modport master (
        output ope, ope_valid, step_ack,
        input ope_ready, step_valid, reg_load, select, step_idx, last_step, adv_valid, num_of_ope, illegal, fault
    );
    modport slave (
        input ope, ope_valid, step_ack,
        output ope_ready, step_valid, reg_load, select, step_idx, last_step, adv_valid, num_of_ope, illegal, fault
    );
endinterface

// File: rtl/microstep_decode.sv
// microstep_decode: captures an instruction, issues its ALU micro-steps with back-pressure,
// then pulses the EIP advance length; undefined opcodes trap into a sticky fault.
module microstep_decode #(
    parameter int OPE_W = 32,
    parameter int SEL_W = 4,
    parameter int MAX_STEPS = 3
) (
    input logic clk2,
    input logic reset_n,
    microstep_decode_if.slave bus
);
    localparam int STEP_W = $clog2(MAX_STEPS);
    typedef enum logic [1:0] {IDLE, EXEC, ADV} state_t;
    state_t state, state_n;
    logic [7:0] opc;
    logic [7:0] op_in;
    logic [STEP_W-1:0] idx;
    logic [3:0] len_q;
    logic fault_q;
    logic hs;
    logic last;
    logic [7:0] code;
    function automatic logic legal(input logic [7:0] op);
        return op inside {8'h55, 8'h89, 8'hb8, 8'h5d, 8'hc3, 8'he8};
    endfunction
    function automatic logic [3:0] length(input logic [7:0] op);
        return (op == 8'h89) ? 4'd2 : (op == 8'hb8 || op == 8'he8) ? 4'd5 : 4'd1;
    endfunction
    function automatic logic [STEP_W-1:0] last_idx(input logic [7:0] op);
        return (op == 8'h55 || op == 8'h5d || op == 8'hc3) ? STEP_W'(1) : (op == 8'he8) ? STEP_W'(2) : '0;
    endfunction
    // {load, sel} nibbles for step i of opcode op
    function automatic logic [7:0] step_code(input logic [7:0] op, input logic [STEP_W-1:0] i);
        case (op)
            8'h55: return 8'h11;
            8'h89: return 8'h22;
            8'hb8: return 8'h33;
            8'h5d: return (i == '0) ? 8'h24 : 8'h22;
            8'hc3: return (i == '0) ? 8'h44 : 8'h32;
            8'he8: return (i == '0) ? 8'h11 : (i == STEP_W'(1)) ? 8'h13 : 8'h45;
            default: return 8'h00;
        endcase
    endfunction
    assign op_in = bus.ope[OPE_W-1 -: 8];
    assign hs = bus.ope_valid && bus.ope_ready;
    assign last = state == EXEC && idx == last_idx(opc);
    assign code = step_code(opc, idx);
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = hs ? (legal(op_in) ? EXEC : ADV) : IDLE;
            EXEC: state_n = (bus.step_ack && last) ? ADV : EXEC;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            opc <= '0;
            idx <= '0;
            len_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_n;
            if (hs) opc <= op_in;
            if (hs && !legal(op_in)) fault_q <= 1'b1;
            idx <= (state == EXEC && state_n == EXEC) ? idx + STEP_W'(bus.step_ack) : '0;
            if (state_n == ADV) len_q <= (state == IDLE) ? length(op_in) : length(opc);
        end
    end
    assign bus.ope_ready = state == IDLE && !fault_q;
    assign bus.step_valid = state == EXEC;
    assign bus.reg_load = (state == EXEC) ? SEL_W'(code[7:4]) : '0;
    assign bus.select = (state == EXEC) ? SEL_W'(code[3:0]) : '0;
    assign bus.step_idx = (state == EXEC) ? idx : '0;
    assign bus.last_step = last;
    assign bus.adv_valid = state == ADV;
    assign bus.num_of_ope = len_q;
    assign bus.illegal = state == ADV && !legal(opc);
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_microstep_decode.sv
// tb_microstep_decode: directed-step bench with hand-computed expectations for microstep_decode.
module tb_microstep_decode;
    logic clk2 = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    microstep_decode_if #(.OPE_W(32), .SEL_W(4), .MAX_STEPS(3)) bus ();
    microstep_decode #(.OPE_W(32), .SEL_W(4), .MAX_STEPS(3)) dut (
        .clk2(clk2),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk2 = ~clk2;
    task automatic tick;
        @(posedge clk2);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    // step bundle {step_valid, reg_load, select, step_idx, last_step}
    task automatic st(input string tag, input logic v, input logic [3:0] l, input logic [3:0] s,
                      input logic [1:0] i, input logic la);
        chk(tag, 32'({bus.step_valid, bus.reg_load, bus.select, bus.step_idx, bus.last_step}), 32'({v, l, s, i, la}));
    endtask
    // control bundle {ope_ready, adv_valid, illegal, fault, num_of_ope}
    task automatic ctl(input string tag, input logic r, input logic a, input logic il, input logic f,
                       input logic [3:0] n);
        chk(tag, 32'({bus.ope_ready, bus.adv_valid, bus.illegal, bus.fault, bus.num_of_ope}), 32'({r, a, il, f, n}));
    endtask
    initial begin
        bus.ope = '0;
        bus.ope_valid = 1'b0;
        bus.step_ack = 1'b0;
        #1;
        st("rst_step", 0, 0, 0, 0, 0);
        ctl("rst_ctl", 1, 0, 0, 0, 0);
        tick;
        tick;
        reset_n = 1'b1;
        // 55: two steps then length 1
        bus.ope = 32'h55123456;
        bus.ope_valid = 1'b1;
        bus.step_ack = 1'b1;
        tick;
        bus.ope_valid = 1'b0;
        st("55_s0", 1, 1, 1, 0, 0);
        ctl("55_busy", 0, 0, 0, 0, 0);
        tick;
        st("55_s1", 1, 1, 1, 1, 1);
        tick;
        st("55_adv_step", 0, 0, 0, 0, 0);
        ctl("55_adv", 0, 1, 0, 0, 1);
        tick;
        ctl("55_ready", 1, 0, 0, 0, 1);
        // e8: three steps, length 5
        bus.ope = 32'hE8000010;
        bus.ope_valid = 1'b1;
        tick;
        bus.ope_valid = 1'b0;
        st("e8_s0", 1, 1, 1, 0, 0);
        tick;
        st("e8_s1", 1, 1, 3, 1, 0);
        tick;
        st("e8_s2", 1, 4, 5, 2, 1);
        tick;
        ctl("e8_adv", 0, 1, 0, 0, 5);
        tick;
        ctl("e8_ready", 1, 0, 0, 0, 5);
        // c3 with step_ack held low: step 0 frozen
        bus.ope = 32'hC3000000;
        bus.ope_valid = 1'b1;
        bus.step_ack = 1'b0;
        tick;
        bus.ope_valid = 1'b0;
        st("c3_s0", 1, 4, 4, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            st($sformatf("c3_hold%0d", k), 1, 4, 4, 0, 0);
        end
        ctl("c3_hold_ctl", 0, 0, 0, 0, 5);
        bus.step_ack = 1'b1;
        tick;
        st("c3_s1", 1, 3, 2, 1, 1);
        tick;
        ctl("c3_adv", 0, 1, 0, 0, 1);
        tick;
        ctl("c3_ready", 1, 0, 0, 0, 1);
        // 89, b8, 5d back-to-back with ope changing while busy
        bus.ope = 32'h89000000;
        bus.ope_valid = 1'b1;
        tick;
        st("89_s0", 1, 2, 2, 0, 1);
        bus.ope = 32'h5D000000;
        tick;
        st("89_adv_step", 0, 0, 0, 0, 0);
        ctl("89_adv", 0, 1, 0, 0, 2);
        bus.ope = 32'hB8000000;
        tick;
        ctl("89_ready", 1, 0, 0, 0, 2);
        st("89_idle_step", 0, 0, 0, 0, 0);
        tick;
        st("b8_s0", 1, 3, 3, 0, 1);
        bus.ope = 32'h55000000;
        tick;
        ctl("b8_adv", 0, 1, 0, 0, 5);
        bus.ope = 32'h5D000000;
        tick;
        ctl("b8_ready", 1, 0, 0, 0, 5);
        tick;
        st("5d_s0", 1, 2, 4, 0, 0);
        bus.ope = 32'hC3000000;
        tick;
        st("5d_s1", 1, 2, 2, 1, 1);
        bus.ope_valid = 1'b0;
        tick;
        ctl("5d_adv", 0, 1, 0, 0, 1);
        tick;
        ctl("5d_ready", 1, 0, 0, 0, 1);
        // reset during e8 step 1
        bus.ope = 32'hE8000010;
        bus.ope_valid = 1'b1;
        tick;
        bus.ope_valid = 1'b0;
        tick;
        st("e8r_s1", 1, 1, 3, 1, 0);
        reset_n = 1'b0;
        #1;
        st("e8r_rst_step", 0, 0, 0, 0, 0);
        ctl("e8r_rst_ctl", 1, 0, 0, 0, 0);
        tick;
        reset_n = 1'b1;
        tick;
        ctl("e8r_no_adv", 1, 0, 0, 0, 0);
        bus.ope = 32'h89ABCDEF;
        bus.ope_valid = 1'b1;
        tick;
        bus.ope_valid = 1'b0;
        st("post_89_s0", 1, 2, 2, 0, 1);
        tick;
        ctl("post_89_adv", 0, 1, 0, 0, 2);
        tick;
        // illegal opcode: one-cycle trap pulse, then sticky fault
        bus.ope = 32'hFF000000;
        bus.ope_valid = 1'b1;
        tick;
        ctl("ff_adv", 0, 1, 1, 1, 1);
        st("ff_step", 0, 0, 0, 0, 0);
        bus.ope = 32'h55000000;
        tick;
        ctl("ff_after", 0, 0, 0, 1, 1);
        tick;
        tick;
        st("ff_blocked_step", 0, 0, 0, 0, 0);
        ctl("ff_blocked", 0, 0, 0, 1, 1);
        reset_n = 1'b0;
        #1;
        ctl("ff_rst", 1, 0, 0, 0, 0);
        tick;
        reset_n = 1'b1;
        tick;
        st("ff_recover_s0", 1, 1, 1, 0, 0);
        bus.ope_valid = 1'b0;
        tick;
        st("ff_recover_s1", 1, 1, 1, 1, 1);
        tick;
        ctl("ff_recover_adv", 0, 1, 0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/microstep_decode.md
# microstep_decode

Parametrised successor to the single-cycle opcode decoder. Captures one instruction word per handshake, decodes the leading opcode byte, and issues its ALU micro-steps (register-load target and ALU input select) one per accepted step. It then reports the EIP advance length. It sits between the fetch stage and the ALU/register-file control, and supports up to MAX_STEPS steps per instruction with back-pressure, plus illegal-opcode trapping.

## Interface
- OPE_W, 32, instruction word width (≥8); opcode = ope[OPE_W-1:OPE_W-8]
- SEL_W, 4, width of reg_load and select codes (≥4)
- MAX_STEPS, 3, maximum micro-steps per instruction (≥3)
- STEP_W, $clog2(MAX_STEPS), width of step_idx
- clk2  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ope  in  OPE_W  instruction word from fetch
- ope_valid  in  1  ope is valid
- ope_ready  out  1  block can accept ope
- step_ack  in  1  consumer accepts the current step
- step_valid  out  1  reg_load/select/step_idx are valid
- reg_load  out  SEL_W  ALU output destination for this step
- select  out  SEL_W  ALU input source for this step
- step_idx  out  STEP_W  index of the current step (0-based)
- last_step  out  1  current step is the final one
- adv_valid  out  1  one-cycle pulse: num_of_ope is valid for the EIP adder
- num_of_ope  out  4  instruction length in bytes
- illegal  out  1  pulses with adv_valid when the opcode is undefined
- fault  out  1  sticky; set by an illegal opcode, cleared only by reset

## Operation
- Decode table (opcode: length; steps as load/sel):
  - 55: len 1; 1/1, 1/1
  - 89: len 2; 2/2
  - b8: len 5; 3/3
  - 5d: len 1; 2/4, 2/2
  - c3: len 1; 4/4, 3/2
  - e8: len 5; 1/1, 1/3, 4/5 (new third step: EIP <= EIP + rel32)
  - other opcodes: illegal; len 1; no steps
- Codes are zero-extended to SEL_W. reg_load, select and step_idx read 0 whenever step_valid=0 (never X).
- States:
  - IDLE: ope_ready = !fault. On ope_valid&&ope_ready, capture the opcode. Go to EXEC (legal) or ADV (illegal, set fault).
  - EXEC: step_valid=1. On step_ack, if not last, increment step_idx and stay; if last, go to ADV.
  - ADV: adv_valid=1 for exactly one cycle, with num_of_ope = captured length. illegal=1 if the opcode was undefined. Go to IDLE.
- The opcode is sampled only at the handshake. ope changes at any other time have no effect.
- step_ack is ignored outside EXEC. ope_valid is ignored while ope_ready=0.
- While fault=1, the block stays in IDLE with ope_ready=0 until reset.

## Timing
- Reset (async assert, sync to clk2 on release): state IDLE, fault=0, step_valid=0, adv_valid=0, illegal=0, num_of_ope=0, reg_load=0, select=0, step_idx=0, last_step=0, ope_ready=1.
- Handshake at edge T: step 0 is visible from T+1. With step_ack held high, step k is visible at T+1+k. For an n-step opcode, adv_valid is high in cycle T+n+1, and ope_ready returns to 1 at T+n+2.
- Illegal opcode at edge T: adv_valid=illegal=1 in cycle T+1, fault=1 from T+1, ope_ready stays 0.
- Throughput: one instruction per n+2 cycles at best. No back-to-back overlap.
- Holding step_ack low freezes all step outputs indefinitely.
- last_step is combinational from the registered step_idx and opcode.
- Reset asserted mid-EXEC or mid-ADV: outputs go immediately to reset values, and the adv_valid pulse is lost.
- num_of_ope holds its last value outside ADV.

## Test plan
- Reset, then ope=32'h55xxxxxx with ope_valid, step_ack=1 -> steps 1/1, 1/1 on consecutive cycles; adv_valid with num_of_ope=1 at T+3; ope_ready=1 at T+4.
- ope=32'hE8000010, step_ack=1 -> three steps 1/1, 1/3, 4/5 with step_idx 0,1,2 and last_step only on step 2; num_of_ope=5.
- ope=32'hC3000000, step_ack low 4 cycles after step 0 -> step 0 (4/4) held stable 5 cycles; step 1 (3/2) follows the ack.
- ope=32'hFF000000 -> illegal=adv_valid=1 for one cycle, num_of_ope=1, fault=1; further ope_valid not accepted until reset_n pulse.
- Sequence 89, b8, 5d back-to-back -> num_of_ope 2, 5, 1; no step or pulse overlap; ope changes while busy ignored.
- reset_n low during EXEC of e8 step 1 -> step_valid=0 immediately; after release, ope_ready=1 and the next opcode decodes normally.
